switch_box: RTL and testbench
=============================

SWITCH_BOX -- requirements
Module: switch_box

Interface
REQ-001 Parameter: WIDTH, default 5, number of tracks per side.
REQ-002 Derived constant: CONFIG_WIDTH = 8*WIDTH (40 at default); not overridable.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 config_clk  input  1  config shift clock; the block's only clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 config_en  input  1  shift enable for the configuration chain.
REQ-007 config_in  input  1  serial configuration data in.
REQ-008 config_out  output  1  serial configuration data out, for daisy-chaining.
REQ-009 l_in, r_in, t_in, b_in  input  WIDTH each  track inputs: left, right, top, bottom.
REQ-010 l_out, r_out, t_out, b_out  output  WIDTH each  track outputs: left, right, top, bottom.

Function
REQ-011 The block SHALL hold a CONFIG_WIDTH-bit register cfg.
REQ-012 On a rising config_clk edge with rst=0 and config_en=1: cfg SHALL shift right one place; config_in enters cfg[CONFIG_WIDTH-1]; the old cfg[0] leaves.
REQ-013 When config_en=0, cfg SHALL hold its value.
REQ-014 config_out SHALL equal cfg[0] combinationally.
REQ-015 After CONFIG_WIDTH enabled clocks with the word presented LSB first, cfg SHALL equal that word; bit i enters on clock i.
REQ-016 Each track i SHALL own the byte cfg[8i+7:8i]. Field layout:
- [1:0] selects l_out[i]
- [3:2] selects r_out[i]
- [5:4] selects t_out[i]
- [7:6] selects b_out[i]
REQ-017 l_out[i] select codes: 00 -> 0, 01 -> r_in[i], 10 -> t_in[i], 11 -> b_in[i].
REQ-018 r_out[i] select codes: 00 -> 0, 01 -> l_in[i], 10 -> t_in[i], 11 -> b_in[i].
REQ-019 t_out[i] select codes: 00 -> 0, 01 -> b_in[i], 10 -> l_in[i], 11 -> r_in[i].
REQ-020 b_out[i] select codes: 00 -> 0, 01 -> t_in[i], 10 -> l_in[i], 11 -> r_in[i].
REQ-021 Select code 01 SHALL always mean the opposite side (straight-through).
REQ-022 Track outputs SHALL be purely combinational from the inputs and cfg: zero latency, no registers in the data path.
REQ-023 Tracks SHALL be disjoint: track i never connects to track j for i != j.
REQ-024 During shifting, outputs SHALL follow the current cfg every cycle; no glitch protection or shadow register is provided.
REQ-025 Several outputs MAY select the same input; fan-out is unrestricted.

Reset
REQ-026 rst=1 on a rising config_clk edge SHALL clear cfg to all zeros, overriding config_en.
REQ-027 After reset: all track outputs = 0 and config_out = 0.
REQ-028 Reset asserted in the middle of a configuration sequence SHALL discard the partial configuration.

Structure
REQ-029 Shared package contents: the select-code constants SEL_OFF=2'b00, SEL_OPP=2'b01, SEL_A=2'b10, SEL_B=2'b11, and the per-track field offsets.
REQ-030 One sub-module SHALL be used: sb_track, a combinational single-track 4-output mux driven by an 8-bit configuration, instantiated WIDTH times by a generate loop.
REQ-031 The cfg shift register SHALL reside in switch_box.

Verification
REQ-032 Reset then idle: rst pulse, any track inputs -> all outputs 0, config_out 0.
REQ-033 Straight-through: shift 40'h10_10_10_10_10 (every track byte 8'h10, i.e. t_out field = 01) LSB first; drive b_in=5'b10101 -> t_out=5'b10101; l_out, r_out, b_out = 0.
REQ-034 All-opposite: every track byte 8'h55; drive l_in=5'h1F, others 0 -> r_out=5'h1F, all other outputs 0; then r_in=5'h03 alone -> l_out=5'h03.
REQ-035 Turn codes: every track byte 8'hAA; drive t_in=5'h0A -> l_out=5'h0A and r_out=5'h0A; drive l_in=5'h11 -> t_out=5'h11 and b_out=5'h11.
REQ-036 Chain passthrough: shift word W, then 40 more bits with config_en=1 -> config_out reproduces W LSB first; config_en=0 for 10 clocks -> cfg unchanged.
REQ-037 Mid-shift reset: rst asserted after 17 of 40 bits -> cfg = 0 and all outputs 0.

Source files
------------

// File: rtl/switch_box_pkg.sv
// switch_box_pkg -- shared constants for the switch box.
//   Select codes used by every track output field, the bit offsets of
//   each output's field inside a track's configuration byte, and a small
//   4:1 select helper shared by the track mux.
package switch_box_pkg;

  localparam int DEF_WIDTH  = 5;
  localparam int TRACK_BITS = 8;

  localparam logic [1:0] SEL_OFF = 2'b00;
  localparam logic [1:0] SEL_OPP = 2'b01;
  localparam logic [1:0] SEL_A   = 2'b10;
  localparam logic [1:0] SEL_B   = 2'b11;

  // Field offsets inside a track byte
  localparam int L_OFF = 0;
  localparam int R_OFF = 2;
  localparam int T_OFF = 4;
  localparam int B_OFF = 6;

  // Code 01 is always the opposite side; A/B are the two turn sources.
  function automatic logic sel_src(logic [1:0] code, logic opp, logic a, logic b);
    case (code)
      SEL_OPP: sel_src = opp;
      SEL_A:   sel_src = a;
      SEL_B:   sel_src = b;
      default: sel_src = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/switch_box_if.sv
// switch_box_if -- track buses of the switch box.
//   l/r/t/b_in  : WIDTH-bit track inputs (left, right, top, bottom)
//   l/r/t/b_out : WIDTH-bit track outputs
//   master drives the inputs and observes the outputs; slave is the box.
interface switch_box_if
  import switch_box_pkg::*;
#(parameter int WIDTH = DEF_WIDTH);

  logic [WIDTH-1:0] l_in, r_in, t_in, b_in;
  logic [WIDTH-1:0] l_out, r_out, t_out, b_out;

  modport master (
    output l_in, r_in, t_in, b_in,
    input  l_out, r_out, t_out, b_out
  );

  modport slave (
    input  l_in, r_in, t_in, b_in,
    output l_out, r_out, t_out, b_out
  );

endinterface

// File: rtl/switch_box_track.sv
// sb_track -- single-track 4-output combinational mux.
//   cfg       : 8-bit track configuration ([1:0] l, [3:2] r, [5:4] t, [7:6] b)
//   l/r/t/b_in: the track's bit on each side
//   l/r/t/b_out: the track's output bit on each side
module sb_track
  import switch_box_pkg::*;
(
  input  logic [TRACK_BITS-1:0] cfg,
  input  logic                  l_in,
  input  logic                  r_in,
  input  logic                  t_in,
  input  logic                  b_in,
  output logic                  l_out,
  output logic                  r_out,
  output logic                  t_out,
  output logic                  b_out
);

  // Horizontal outputs turn to top/bottom; vertical outputs turn to left/right.
  assign l_out = sel_src(cfg[L_OFF +: 2], r_in, t_in, b_in);
  assign r_out = sel_src(cfg[R_OFF +: 2], l_in, t_in, b_in);
  assign t_out = sel_src(cfg[T_OFF +: 2], b_in, l_in, r_in);
  assign b_out = sel_src(cfg[B_OFF +: 2], t_in, l_in, r_in);

endmodule

// File: rtl/switch_box.sv
// switch_box -- configurable track switch box with serial config chain.
//   config_clk : config shift clock (only clock)
//   rst        : synchronous active-high reset, clears cfg
//   config_en  : shift enable for the cfg chain
//   config_in  : serial config data in (enters cfg MSB)
//   config_out : cfg[0], for daisy-chaining the next box
//   tracks     : track buses (switch_box_if.slave)
// Track outputs are purely combinational from the track inputs and cfg,
// so they follow cfg while it is being shifted.
module switch_box
  import switch_box_pkg::*;
#(parameter int WIDTH = DEF_WIDTH)
(
  input  logic         config_clk,
  input  logic         rst,
  input  logic         config_en,
  input  logic         config_in,
  output logic         config_out,
  switch_box_if.slave  tracks
);

  localparam int CONFIG_WIDTH = TRACK_BITS * WIDTH;

  logic [CONFIG_WIDTH-1:0] cfg;

  // Right shift: a word presented LSB first lands with bit 0 at cfg[0].
  always_ff @(posedge config_clk) begin
    if (rst)            cfg <= '0;
    else if (config_en) cfg <= {config_in, cfg[CONFIG_WIDTH-1:1]};
  end

  assign config_out = cfg[0];

  for (genvar i = 0; i < WIDTH; i++) begin : g_track
    sb_track u_track (
      .cfg   (cfg[TRACK_BITS*i +: TRACK_BITS]),
      .l_in  (tracks.l_in[i]),
      .r_in  (tracks.r_in[i]),
      .t_in  (tracks.t_in[i]),
      .b_in  (tracks.b_in[i]),
      .l_out (tracks.l_out[i]),
      .r_out (tracks.r_out[i]),
      .t_out (tracks.t_out[i]),
      .b_out (tracks.b_out[i])
    );
  end

endmodule

// File: tb/tb_switch_box.sv
module tb_switch_box;
  localparam int W  = 5;
  localparam int CW = 8 * W;

  logic config_clk = 1'b0;
  logic rst = 1'b0;
  logic config_en = 1'b0;
  logic config_in = 1'b0;
  logic config_out;

  int vectors = 0;
  int miscompares = 0;

  logic [CW-1:0] cfg_m;

  switch_box_if #(.WIDTH(W)) bus ();

  switch_box #(.WIDTH(W)) dut (
    .config_clk (config_clk),
    .rst        (rst),
    .config_en  (config_en),
    .config_in  (config_in),
    .config_out (config_out),
    .tracks     (bus)
  );

  always #5 config_clk = ~config_clk;

  // Reference: for each track, field at 'off' picks from {0, opp, a, b}.
  function automatic logic [W-1:0] ref_out(logic [CW-1:0] c, int off,
                                           logic [W-1:0] opp, logic [W-1:0] a,
                                           logic [W-1:0] b);
    logic [W-1:0] srcs [4];
    logic [W-1:0] r;
    srcs[0] = '0; srcs[1] = opp; srcs[2] = a; srcs[3] = b;
    r = '0;
    for (int i = 0; i < W; i++) r[i] = srcs[c[8*i+off +: 2]][i];
    return r;
  endfunction

  task automatic chk(string tag, logic [CW-1:0] got, logic [CW-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, "/l_out"}, CW'(bus.l_out), CW'(ref_out(cfg_m, 0, bus.r_in, bus.t_in, bus.b_in)));
    chk({tag, "/r_out"}, CW'(bus.r_out), CW'(ref_out(cfg_m, 2, bus.l_in, bus.t_in, bus.b_in)));
    chk({tag, "/t_out"}, CW'(bus.t_out), CW'(ref_out(cfg_m, 4, bus.b_in, bus.l_in, bus.r_in)));
    chk({tag, "/b_out"}, CW'(bus.b_out), CW'(ref_out(cfg_m, 6, bus.t_in, bus.l_in, bus.r_in)));
    chk({tag, "/config_out"}, CW'(config_out), CW'(cfg_m[0]));
  endtask

  task automatic drive(logic [W-1:0] l, logic [W-1:0] r, logic [W-1:0] t, logic [W-1:0] b);
    bus.l_in = l; bus.r_in = r; bus.t_in = t; bus.b_in = b;
    #1;
  endtask

  task automatic step(logic en, logic din);
    config_en = en; config_in = din;
    @(posedge config_clk);
    if (en) cfg_m = {din, cfg_m[CW-1:1]};
    #1;
  endtask

  task automatic shift_word(logic [CW-1:0] w);
    for (int k = 0; k < CW; k++) step(1'b1, w[k]);
    config_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; config_en = 1'b1; config_in = 1'b1;
    @(posedge config_clk);
    cfg_m = '0;
    #1;
    rst = 1'b0; config_en = 1'b0; config_in = 1'b0;
  endtask

  function automatic logic [CW-1:0] rep_byte(logic [7:0] b);
    return {W{b}};
  endfunction

  initial begin
    logic [CW-1:0] w;
    cfg_m = '0;
    bus.l_in = '0; bus.r_in = '0; bus.t_in = '0; bus.b_in = '0;
    #2;

    // Reset then idle
    do_reset();
    drive(5'h1F, 5'h1F, 5'h1F, 5'h1F);
    chk("rst/cfg", dut.cfg, '0);
    chk("rst/l_out", CW'(bus.l_out), '0);
    chk("rst/r_out", CW'(bus.r_out), '0);
    chk("rst/t_out", CW'(bus.t_out), '0);
    chk("rst/b_out", CW'(bus.b_out), '0);
    chk("rst/config_out", CW'(config_out), '0);

    // Straight-through top from bottom
    shift_word(rep_byte(8'h10));
    drive(5'h00, 5'h00, 5'h00, 5'b10101);
    chk("st/cfg", dut.cfg, 40'h10_10_10_10_10);
    chk("st/t_out", CW'(bus.t_out), CW'(5'b10101));
    chk("st/l_out", CW'(bus.l_out), '0);
    chk("st/r_out", CW'(bus.r_out), '0);
    chk("st/b_out", CW'(bus.b_out), '0);
    check_model("st");

    // All-opposite
    shift_word(rep_byte(8'h55));
    drive(5'h1F, 5'h00, 5'h00, 5'h00);
    chk("opp/r_out", CW'(bus.r_out), CW'(5'h1F));
    chk("opp/l_out", CW'(bus.l_out), '0);
    chk("opp/t_out", CW'(bus.t_out), '0);
    chk("opp/b_out", CW'(bus.b_out), '0);
    drive(5'h00, 5'h03, 5'h00, 5'h00);
    chk("opp/l_out2", CW'(bus.l_out), CW'(5'h03));
    chk("opp/r_out2", CW'(bus.r_out), '0);
    check_model("opp");

    // Turn codes (10)
    shift_word(rep_byte(8'hAA));
    drive(5'h00, 5'h00, 5'h0A, 5'h00);
    chk("turn/l_out", CW'(bus.l_out), CW'(5'h0A));
    chk("turn/r_out", CW'(bus.r_out), CW'(5'h0A));
    drive(5'h11, 5'h00, 5'h00, 5'h00);
    chk("turn/t_out", CW'(bus.t_out), CW'(5'h11));
    chk("turn/b_out", CW'(bus.b_out), CW'(5'h11));
    check_model("turn");

    // Chain passthrough: W reappears on config_out LSB first
    w = {$urandom, $urandom};
    shift_word(w);
    chk("chain/cfg", dut.cfg, w);
    for (int k = 0; k < CW; k++) begin
      chk($sformatf("chain/out%0d", k), CW'(config_out), CW'(w[k]));
      step(1'b1, 1'($urandom));
    end
    config_en = 1'b0;
    w = cfg_m;
    for (int k = 0; k < 10; k++) step(1'b0, 1'($urandom));
    chk("hold/cfg", dut.cfg, w);
    check_model("hold");

    // Mid-shift reset discards partial config
    shift_word(rep_byte(8'hFF));
    for (int k = 0; k < 17; k++) step(1'b1, 1'b1);
    do_reset();
    drive(5'h1F, 5'h1F, 5'h1F, 5'h1F);
    chk("midrst/cfg", dut.cfg, '0);
    check_model("midrst");

    // Randomized configs and inputs, checked every cycle during shifting
    for (int n = 0; n < 12; n++) begin
      w = {$urandom, $urandom};
      for (int k = 0; k < CW; k++) begin
        step(1'b1, w[k]);
        if (k % 8 == 7) begin
          drive(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
          check_model("rnd/shift");
        end
      end
      config_en = 1'b0;
      chk("rnd/cfg", dut.cfg, w);
      for (int j = 0; j < 4; j++) begin
        drive(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
        check_model("rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
